// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer slice.
package stream_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Round-robin successor of a granted channel: the channel after g, wrapping at n.
  function automatic int unsigned next_ptr(input int unsigned g, input int unsigned n);
    return (g == (n - 32'd1)) ? 32'd0 : (g + 32'd1);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N_CH producers, the multiplexer and one consumer.
interface stream_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  // Producer/consumer environment side.
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  // Multiplexer side.
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_rr_rr_pick.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then rotate the index back into channel numbering.
module rr_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [2*N_CH-1:0] dbl_s;
  logic [N_CH-1:0]   rot_s;
  int                off_s;
  int                sum_s;
  logic              found_s;

  // Rotate, lowest-index priority encode, and un-rotate.
  always_comb begin
    dbl_s   = {req, req} >> ptr;
    rot_s   = dbl_s[N_CH-1:0];
    off_s   = 0;
    found_s = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      off_s   = rot_s[i] ? i : off_s;
      found_s = found_s | rot_s[i];
    end
    sum_s = int'(ptr) + off_s;
    sum_s = (sum_s >= N_CH) ? (sum_s - N_CH) : sum_s;
    gnt_valid = found_s;
    gnt_idx   = SEL_W'(sum_s);
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream multiplexer with manual or round-robin selection feeding a
// single registered output stage with backpressure.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  stream_mux_rr_if.slave bus
);

  localparam int SEL_W = $clog2(N_CH);

  out_state_t        state_r;
  out_state_t        state_nxt_s;
  logic [WIDTH-1:0]  out_data_r;
  logic [SEL_W-1:0]  out_ch_r;
  logic [SEL_W-1:0]  rr_ptr_r;

  logic              can_load_s;
  logic              pick_valid_s;
  logic [SEL_W-1:0]  pick_idx_s;
  logic              manual_hit_s;
  logic              grant_valid_s;
  logic [SEL_W-1:0]  g_s;
  logic [N_CH-1:0]   in_ready_s;
  logic [WIDTH-1:0]  sel_data_s;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_r),
    .gnt_valid (pick_valid_s),
    .gnt_idx   (pick_idx_s)
  );

  // Arbitration: pick the granted channel and raise exactly its ready.
  // A select value with no matching channel simply produces no hit.
  always_comb begin
    can_load_s   = (state_r == ST_EMPTY) | bus.out_ready;
    manual_hit_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      manual_hit_s = manual_hit_s | ((bus.sel == SEL_W'(i)) & bus.in_valid[i]);
    end
    if (bus.mode == MODE_RR) begin
      grant_valid_s = can_load_s & pick_valid_s;
      g_s           = pick_idx_s;
    end else begin
      grant_valid_s = can_load_s & manual_hit_s;
      g_s           = bus.sel;
    end
    in_ready_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready_s[i] = grant_valid_s & (g_s == SEL_W'(i));
      sel_data_s    = (g_s == SEL_W'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  // Output stage next state: an accept always fills, a drain without accept empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (grant_valid_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (grant_valid_s) begin
          state_nxt_s = ST_FULL;
        end else if (bus.out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Output stage state register; reset discards any held word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and round-robin pointer: load on accept, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r <= '0;
      out_ch_r   <= '0;
      rr_ptr_r   <= '0;
    end else if (grant_valid_s) begin
      out_data_r <= sel_data_s;
      out_ch_r   <= g_s;
      rr_ptr_r   <= SEL_W'(next_ptr(32'(g_s), 32'(N_CH)));
    end else begin
      out_data_r <= out_data_r;
      out_ch_r   <= out_ch_r;
      rr_ptr_r   <= rr_ptr_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_valid = (state_r == ST_FULL);

endmodule
